mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: the instruction-fetch path (IF) and the load/store data path (D).
- Sits between the multi-cycle core's fetch/memory stages and the memory model.
- Arbitrates requests, latches the winner's command, drives the memory handshake and returns registered read data with a one-cycle ready pulse.
- A wait-state watchdog converts a hung memory into an error completion.

Parameters:
DATA_WIDTH, 32, data and address width in bits
TIMEOUT_CYCLES, 64, maximum BUSY cycles before a forced error completion; 0 disables the watchdog
CNT_WIDTH, 8, width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, level; held until if_ready
if_addr  in  DATA_WIDTH  fetch address; always word read, signed
if_rdata  out  DATA_WIDTH  fetched word, registered
if_ready  out  1  one-cycle completion pulse to IF
if_err  out  1  qualifies if_ready; watchdog expiry
d_req  in  1  data request, level; held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  DATA_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_size  in  2  mem_size_t encoding (B/H/W)
d_sign  in  1  load sign-extension select
d_rdata  out  DATA_WIDTH  load data, registered
d_ready  out  1  one-cycle completion pulse to D
d_err  out  1  qualifies d_ready; watchdog expiry
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  DATA_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched store data
mem_size  out  2  latched size; MEM_SIZE_W for fetch
mem_sign  out  1  latched sign; 1 for fetch
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req = 1

Behaviour:
- Reset: state IDLE.
  - All outputs are 0.
  - Wait counter is 0; last_grant = IF.
  - Reset mid-transaction abandons the transaction: mem_req is 0 in the cycle after the reset edge, and no ready pulse is issued.
- States: IDLE, BUSY, DONE; registered owner flag (IF or D).
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick the winner.
  - Default tie rule: D wins.
  - Latch addr, wdata, we, size and sign of the winner into the mem_* registers.
  - Fetch transactions latch we = 0, size = W, sign = 1, wdata = 0.
  - Go to BUSY.
- BUSY:
  - mem_req = 1 and all mem_* fields are held stable; the counter increments each cycle.
  - mem_ready = 1: capture mem_rdata into the owner's rdata register (loads and fetches only; a store leaves rdata unchanged). Clear mem_req and mem_we, go to DONE.
  - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES without mem_ready: clear mem_req, set the owner's err, go to DONE. rdata is not updated.
- DONE:
  - The owner's ready = 1 for exactly one cycle, with err valid alongside it.
  - New requests are ignored; next state is IDLE, with the counter and err cleared.
- Requester rule: the requester deasserts req at the edge where it samples ready = 1. Any req seen high in IDLE is treated as a new transaction.
- Non-owner req stays pending and is never dropped; it is served on the next IDLE.
- Latency with a zero-wait memory (mem_ready = 1 in the first BUSY cycle):
  - req sampled in IDLE at cycle 0.
  - mem_req = 1 in cycle 1.
  - ready = 1 in cycle 2.
  - Back-to-back transactions achieve one per 3 cycles.
- req fields changing during BUSY have no effect, since the command is latched.
- mem_ready while not in BUSY is ignored.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous if_req and d_req in IDLE, the requester that did not win the previous grant wins. last_grant updates on every grant.
- Undefined: fixed priority, D always wins ties; last_grant is unused.

Test Plan:
- if_req = 1, if_addr = 0x0000_0010, memory returns 0x0050_0093 with zero wait → mem_req high in cycle 1 with mem_addr = 0x10, mem_we = 0, mem_size = W; if_ready pulses in cycle 2 with if_rdata = 0x0050_0093 and if_err = 0.
- d_req store, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, size = B, memory waits 3 cycles → mem_we = 1 with fields stable for 4 BUSY cycles; d_ready is a single pulse; d_rdata is unchanged.
- if_req and d_req asserted in the same cycle → D granted first and IF served on the next IDLE. With ARB_ROUND_ROBIN_EN after a prior D grant, IF is granted first.
- TIMEOUT_CYCLES = 4, mem_ready tied 0 → mem_req drops after 4 BUSY cycles; ready and err pulse together; the next transaction completes normally.
- rst asserted in the second BUSY cycle of a load → mem_req = 0 on the next cycle; no d_ready pulse; state IDLE; a fresh request afterwards completes with 3-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and D with a BUSY watchdog; ARB_ROUND_ROBIN_EN makes ties alternate
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_size,
  input  logic                  d_sign,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_size,
  output logic                  mem_sign,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic start, grant, timeout, finish, cap;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    start   = (state_q == IDLE) && (if_req || d_req);
    timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    finish  = (state_q == BUSY) && (mem_ready || timeout);
    state_d = state_q == IDLE ? (start ? BUSY : IDLE) :
              state_q == BUSY ? (finish ? DONE : BUSY) : IDLE;
  end

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant        = d_req && !(if_req && last_grant_q);
    last_grant_d = start ? grant : last_grant_q;
`else
    grant        = d_req;
`endif
    owner_d    = start ? grant : owner_q;
    addr_d     = start ? (grant ? d_addr : if_addr) : addr_q;
    wdata_d    = start ? (grant ? d_wdata : '0) : wdata_q;
    size_d     = start ? (grant ? d_size : MEM_SIZE_W) : size_q;
    sign_d     = start ? (grant ? d_sign : 1'b1) : sign_q;
    we_d       = start ? (grant && d_we) : (finish ? 1'b0 : we_q);
    cnt_d      = state_q == BUSY ? cnt_q + 1'b1 : '0;
    err_d      = state_q == BUSY ? (timeout && !mem_ready) : (state_q == DONE ? 1'b0 : err_q);
    cap        = (state_q == BUSY) && mem_ready && !we_q;
    if_rdata_d = cap && !owner_q ? mem_rdata : if_rdata_q;
    d_rdata_d  = cap && owner_q ? mem_rdata : d_rdata_q;
  end

  always_comb begin
    mem_req   = state_q == BUSY;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_size  = size_q;
    mem_sign  = sign_q;
    if_ready  = (state_q == DONE) && !owner_q;
    d_ready   = (state_q == DONE) && owner_q;
    if_err    = if_ready && err_q;
    d_err     = d_ready && err_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end
endmodule
